// File: rtl/red_secuencial.sv
`default_nettype none
// ============================================================================
// red_secuencial : serial MSB-first unsigned comparator, Zout = (A > B), one bit/clk
// Option macro RED_EARLY_EXIT_EN : finish as soon as {P,Q} is decided.  Rev 1.0
// ============================================================================
module red_secuencial #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         Zout,
   output logic [1:0]   pq
);
   localparam int IW = (N > 2) ? $clog2(N) : 1;
`ifdef RED_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif
   localparam logic [IW-1:0] IDX_MSB = IW'(N - 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);
   localparam logic [IW-1:0] IDX_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_INIT  = 2'd1,
      S_SHIFT = 2'd2,
      S_FINAL = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [1:0]    pq_q, pq_d;
   logic          zout_q, zout_d;
   logic          done_q, done_d;
   logic          bit_a, bit_b;
   logic [1:0]    cell_pq;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         pq_q    <= 2'b00;
         zout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         pq_q    <= pq_d;
         zout_q  <= zout_d;
         done_q  <= done_d;
      end
   end

   // The single reused cell: with {P,Q} cleared it is also the initial cell.
   always_comb begin
      bit_a   = a_q[idx_q];
      bit_b   = b_q[idx_q];
      cell_pq = (pq_q == 2'b00) ? {bit_a & ~bit_b, ~bit_a & bit_b} : pq_q;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      pq_d    = pq_q;
      zout_d  = zout_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               pq_d    = 2'b00;
               idx_d   = IDX_MSB;
               state_d = S_INIT;
            end
         end
         S_INIT, S_SHIFT: begin
            pq_d  = cell_pq;
            idx_d = (idx_q != IDX_ZERO) ? idx_q - IDX_ONE : idx_q;
            if (idx_q == IDX_ONE || (EARLY_EXIT && cell_pq != 2'b00)) begin
               state_d = S_FINAL;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_FINAL: begin
            zout_d  = pq_q[1] | (~pq_q[1] & ~pq_q[0] & a_q[0] & ~b_q[0]);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign Zout = zout_q;
   assign pq   = pq_q;

endmodule
`default_nettype wire

// File: tb/tb_red_secuencial.sv
`default_nettype none
// Bench for red_secuencial: N=3 directed cases plus N=2 / N=8 random sweeps,
// all instances checked every cycle against a transaction-level model.
module tb_red_secuencial;
`ifdef RED_EARLY_EXIT_EN
   localparam int L_MSB = 2;
`else
   localparam int L_MSB = 3;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] start_s = 3'b000;
   logic [7:0] a_s [3];
   logic [7:0] b_s [3];

   wire       busy0, busy1, busy2, done0, done1, done2, z0, z1, z2;
   wire [1:0] pq0, pq1, pq2;
   wire [2:0] busy_v = {busy2, busy1, busy0};
   wire [2:0] done_v = {done2, done1, done0};
   wire [2:0] zout_v = {z2, z1, z0};
   logic [1:0] pq_v [3];
   assign pq_v[0] = pq0;
   assign pq_v[1] = pq1;
   assign pq_v[2] = pq2;

   red_secuencial #(.N(3)) u_dut3 (.clk(clk), .reset(reset), .start(start_s[0]),
      .A(a_s[0][2:0]), .B(b_s[0][2:0]), .busy(busy0), .done(done0), .Zout(z0), .pq(pq0));
   red_secuencial #(.N(2)) u_dut2 (.clk(clk), .reset(reset), .start(start_s[1]),
      .A(a_s[1][1:0]), .B(b_s[1][1:0]), .busy(busy1), .done(done1), .Zout(z1), .pq(pq1));
   red_secuencial #(.N(8)) u_dut8 (.clk(clk), .reset(reset), .start(start_s[2]),
      .A(a_s[2]), .B(b_s[2]), .busy(busy2), .done(done2), .Zout(z2), .pq(pq2));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [1:0] pq_of(input logic [7:0] a, input logic [7:0] b, input int n);
      for (int i = n - 1; i >= 1; i--)
         if (a[i] != b[i]) return a[i] ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic bit gt(input logic [7:0] a, input logic [7:0] b, input int n);
      logic [7:0] m;
      m = 8'((1 << n) - 1);
      return (a & m) > (b & m);
   endfunction

   function automatic int lat(input logic [7:0] a, input logic [7:0] b, input int n);
`ifdef RED_EARLY_EXIT_EN
      for (int i = n - 1; i >= 1; i--)
         if (a[i] != b[i]) return (n - 1 - i) + 2;
`endif
      return n;
   endfunction

   int         nw [3] = '{3, 2, 8};
   int         cnt [3] = '{0, 0, 0};
   int         cur_lat [3] = '{0, 0, 0};
   logic [7:0] ea [3];
   logic [7:0] eb [3];
   bit         exp_done [3];
   bit         exp_z [3];
   logic [1:0] exp_pq [3];
   bit         chk_pq [3];
   bit         model_on = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            cnt[k]      <= 0;
            exp_done[k] <= 1'b0;
            exp_z[k]    <= 1'b0;
            exp_pq[k]   <= 2'b00;
            chk_pq[k]   <= 1'b1;
            model_on    <= 1'b1;
         end else begin
            exp_done[k] <= 1'b0;
            chk_pq[k]   <= 1'b0;
            if (cnt[k] == 0) begin
               if (start_s[k]) begin
                  ea[k]      <= a_s[k];
                  eb[k]      <= b_s[k];
                  cnt[k]     <= lat(a_s[k], b_s[k], nw[k]);
                  cur_lat[k] <= lat(a_s[k], b_s[k], nw[k]);
               end
            end else if (cnt[k] == 1) begin
               cnt[k]      <= 0;
               exp_done[k] <= 1'b1;
               exp_z[k]    <= gt(ea[k], eb[k], nw[k]);
               exp_pq[k]   <= pq_of(ea[k], eb[k], nw[k]);
               chk_pq[k]   <= 1'b1;
            end else begin
               cnt[k] <= cnt[k] - 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit sweep_on = 1'b0;
   int cyc = 0;
   int last_done [3] = '{-1, -1, -1};
   int dcnt [3] = '{0, 0, 0};

   always @(negedge clk) begin
      cyc++;
      if (model_on) begin
         for (int k = 0; k < 3; k++) begin
            chk("busy", k, busy_v[k], cnt[k] != 0);
            chk("done", k, done_v[k], exp_done[k]);
            chk("zout", k, zout_v[k], exp_z[k]);
            if (chk_pq[k]) chk("pq", k, pq_v[k], exp_pq[k]);
            if (done_v[k] && sweep_on) begin
               if (last_done[k] >= 0) chk("done_spacing", k, cyc - last_done[k], cur_lat[k] + 1);
               last_done[k] = cyc;
               dcnt[k]++;
            end
         end
      end
   end

   // ---------------- directed stimulus on the N=3 instance ----------------
   task automatic run_one(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                          input bit exp_z, input logic [1:0] exp_pq, input bit glitch);
      int n;
      int pulses;
      bit got;
      start_s[0] = 1'b1;
      a_s[0] = a;
      b_s[0] = b;
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      if (glitch) begin
         start_s[0] = 1'b1;
         a_s[0] = ~a;
         b_s[0] = ~b;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk);
         n++;
         #1;
         start_s[0] = 1'b0;
         if (done_v[0]) got = 1'b1;
      end
      chk("latency", 0, n, exp_lat);
      chk("zout_at_done", 0, zout_v[0], exp_z);
      chk("pq_at_done", 0, pq_v[0], exp_pq);
      pulses = got ? 1 : 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done_v[0]) pulses++;
      end
      chk("done_pulses", 0, pulses, 1);
   endtask

   initial begin
      int guard;
      for (int k = 0; k < 3; k++) begin
         a_s[k] = 8'h00;
         b_s[k] = 8'h00;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", 0, busy_v[0], 1'b0);
      chk("rst_zout", 0, zout_v[0], 1'b0);
      chk("rst_pq", 0, pq_v[0], 2'b00);
      @(negedge clk);
      reset = 1'b0;
      run_one(8'b010, 8'b000, 3, 1'b1, 2'b10, 1'b0);
      @(negedge clk);
      run_one(8'b101, 8'b101, 3, 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      run_one(8'b011, 8'b100, L_MSB, 1'b0, 2'b01, 1'b0);
      @(negedge clk);
      run_one(8'b100, 8'b011, L_MSB, 1'b1, 2'b10, 1'b0);
      @(negedge clk);
      run_one(8'b110, 8'b001, L_MSB, 1'b1, 2'b10, 1'b1);

      // abort in SHIFT: Zout is 1 from the previous result and must drop to 0
      @(negedge clk);
      start_s[0] = 1'b1;
      a_s[0] = 8'b011;
      b_s[0] = 8'b010;
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("busy_in_shift", 0, busy_v[0], 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort_busy", 0, busy_v[0], 1'b0);
      chk("abort_zout", 0, zout_v[0], 1'b0);
      chk("abort_done", 0, done_v[0], 1'b0);
      guard = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done_v[0]) guard++;
      end
      chk("abort_no_done", 0, guard, 0);
      @(negedge clk);
      run_one(8'b111, 8'b110, 3, 1'b1, 2'b00, 1'b0);

      // back-to-back random sweep with start held high on every instance
      @(negedge clk);
      sweep_on = 1'b1;
      start_s = 3'b111;
      guard = 0;
      while ((dcnt[1] < 1000 || dcnt[2] < 1000) && guard < 12000) begin
         for (int k = 0; k < 3; k++) begin
            a_s[k] = 8'($urandom);
            b_s[k] = 8'($urandom);
         end
         @(negedge clk);
         guard++;
      end
      chk("sweep_in_time", 0, guard < 12000, 1'b1);
      start_s = 3'b000;
      repeat (12) @(negedge clk);
      sweep_on = 1'b0;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/red_secuencial.md
RED_SECUENCIAL -- requirements
Module: red_secuencial

Interface
REQ-001 Parameter N, default 3, is the operand width in bits; legal range N >= 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a comparison; sampled only in IDLE.
REQ-005 A  input  N  operand A; captured on accepted start.
REQ-006 B  input  N  operand B; captured on accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse marking result valid.
REQ-009 Zout  output  1  registered result: 1 iff captured A > captured B (unsigned).
REQ-010 pq  output  2  current iterative state {P,Q}, for debug and waveform viewing.

Function
REQ-011 The block evaluates the same MSB-to-LSB iterative comparison as the combinational network, serially, one bit per clock, reusing one cell's logic.
REQ-012 State encoding {P,Q}: 00 = equal so far, 10 = A greater, 01 = B greater; 11 is unreachable and never produced.
REQ-013 Initial cell (bit N-1): P = A&~B, Q = ~A&B.
REQ-014 Typical cell (bits N-2..1): if {P,Q}=00, apply the initial-cell rule to the current bit; otherwise hold {P,Q}.
REQ-015 Final cell (bit 0): Zout = P | (~P&~Q & A0&~B0).
REQ-016 FSM states: IDLE, INIT, SHIFT, FINAL.
REQ-017 IDLE: when start=1, latch A/B, clear pq, and load bit index = N-1; go to INIT.
REQ-018 INIT: process bit N-1 and decrement the index; go to SHIFT if N>2, otherwise go to FINAL.
REQ-019 SHIFT: process bit idx and decrement the index; go to FINAL after the edge that processes bit 1.
REQ-020 FINAL: register Zout, pulse done for exactly one cycle, and go to IDLE.
REQ-021 Latency: done is high in the cycle after clock edge N counted from the edge that accepted start; the result is visible on the same cycle.
REQ-022 Zout holds its last value until the next FINAL; it does not change on start.
REQ-023 start while busy is ignored; latched operands do not change mid-operation.
REQ-024 start held high continuously allows a new comparison to be accepted in the IDLE cycle immediately following done; back-to-back throughput is one result per N+1 cycles.
REQ-025 The bit index width is ceil(log2 N), minimum 1; the index never wraps below 0.

Reset
REQ-026 While reset=1: state=IDLE, busy=0, done=0, Zout=0, pq=00, index=0, and the operand registers are cleared.
REQ-027 Reset has priority over start and over any in-flight operation; an aborted operation produces no done pulse.
REQ-028 The first start is accepted on the first cycle after reset deasserts.

Configuration
REQ-029 Macro RED_EARLY_EXIT_EN: when defined, INIT or SHIFT jumps directly to FINAL once {P,Q} becomes non-00, so done arrives as soon as the result is decided (minimum 2 edges after start); the result is identical.
REQ-030 Without RED_EARLY_EXIT_EN, latency is always the fixed value of REQ-021, independent of data.

Verification (N=3 unless noted)
REQ-031 A=3'b010, B=3'b000, start pulse -> done 3 edges later, Zout=1, pq=10 at done.
REQ-032 A=3'b101, B=3'b101 -> Zout=0, pq=00 at done; then A=3'b011, B=3'b100 -> Zout=0, pq=01.
REQ-033 start asserted in INIT with different operands -> ignored; result reflects the first operands; exactly one done pulse.
REQ-034 reset asserted during SHIFT -> next cycle busy=0, Zout=0, no done pulse; a new start then completes normally.
REQ-035 With RED_EARLY_EXIT_EN, A=3'b100, B=3'b011 -> done 2 edges after start, Zout=1; without the macro -> 3 edges, Zout=1.
REQ-036 N=2 and N=8: random exhaustive/1000-vector sweep with start held high -> every done carries Zout == (A>B), and done spacing is N+1 cycles.
